seq_unsi_div_16by8: RTL and testbench
=====================================

Name: seq_unsi_div_16by8

Overview:
- Sequential radix-2 restoring unsigned divider. Divides a 2*DW-bit dividend by a DW-bit divisor and returns a DW-bit quotient and a DW-bit remainder.
- It is the inverse of the team's 8x8 unsigned multiplier datapath. A 16-bit product divided by one 8-bit operand recovers the other operand.
- Used by the multiplier error-evaluation and self-check flow, and wherever the design needs an operand back from a product.
- Valid/ready handshake on both the input side and the output side. Computes one quotient bit per cycle.

Parameters:
- DW, 8, width of the divisor, quotient and remainder. The dividend is 2*DW bits.
- CW, $clog2(DW+1), width of the step counter. Derived; do not override.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  dividend and divisor are valid.
- in_ready  out  1  block can accept a new operation.
- dividend  in  2*DW  unsigned dividend.
- divisor  in  DW  unsigned divisor.
- out_valid  out  1  result fields are valid.
- out_ready  in  1  downstream accepts the result.
- quotient  out  DW  unsigned quotient.
- remainder  out  DW  unsigned remainder.
- dz  out  1  divide-by-zero flag.
- ovf  out  1  quotient overflow: dividend[2DW-1:DW] >= divisor, with divisor != 0.

Behaviour:
- Reset (asynchronous, active-high rst):
  - state=IDLE.
  - in_ready=1 after reset is released.
  - out_valid, quotient, remainder, dz, ovf all 0.
  - All internal registers 0.
  - Asserting rst mid-operation aborts the operation. Nothing is output for it.
- State IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready, capture dividend and divisor.
  - If divisor==0: dz=1, ovf=0, quotient=all ones, remainder=dividend[DW-1:0]. Go to DONE.
  - Else if dividend[2DW-1:DW] >= divisor: ovf=1, dz=0, quotient=all ones, remainder=dividend[DW-1:0]. Go to DONE.
  - Else: partial remainder P (DW+1 bits) = {0, dividend[2DW-1:DW]}. Low shift register = dividend[DW-1:0]. Counter=0. Go to CALC.
- State CALC:
  - in_ready=0.
  - Each cycle: T = {P[DW-1:0], msb of low shift register}. Shift the low register left by one.
  - If T >= {0,divisor}: P = T - divisor and shift a 1 into the quotient LSB. Otherwise P = T and shift in a 0.
  - Counter increments each cycle. After DW cycles (counter==DW-1 on the last step), go to DONE.
  - The final quotient and remainder=P[DW-1:0] are registered into the output fields.
- State DONE:
  - out_valid=1, in_ready=0.
  - The output fields hold stable while out_ready=0.
  - On out_valid&&out_ready, go to IDLE. out_valid deasserts the next cycle. quotient, remainder, dz and ovf keep their last values.
- Latency, with the input accepted at edge t:
  - Normal path: out_valid at t+DW+1 (t+9 for DW=8).
  - dz/ovf early-out: out_valid at t+1.
- Throughput: one operation per DW+2 cycles minimum. No acceptance while in CALC or DONE.
- in_valid while in_ready=0 is ignored. Upstream holds its data per the handshake rules.
- Arithmetic:
  - All comparisons and subtractions are unsigned, DW+1 bits wide. No truncation loss.
  - Invariant on the normal path: dividend == quotient*divisor + remainder, and remainder < divisor.
- dz has priority over ovf. The two are never both set.

Decomposition:
- Shared package seq_div_pkg holds:
  - DW_DEF=8.
  - typedef enum {IDLE, CALC, DONE} div_state_t.
  - A localparam for the saturated quotient value (all ones).
- One natural sub-module: div_step. It is the combinational restoring step: inputs P, next bit and divisor; outputs new P and the quotient bit. The bench reuses it for an unrolled reference check.
- The FSM, counter and shift registers stay in the top module.

Test Plan:
- dividend=16'd200, divisor=8'd7 -> quotient=28, remainder=4, dz=0, ovf=0, out_valid exactly 9 cycles after acceptance.
- dividend=16'hFE01, divisor=8'hFF -> quotient=8'hFF, remainder=0, ovf=0. This is the maximal 8x8 product inverted.
- dividend=16'd1234, divisor=0 -> dz=1, ovf=0, quotient=8'hFF, remainder=8'hD2, out_valid 1 cycle after acceptance.
- dividend=16'h1234, divisor=8'h12 -> ovf=1, dz=0, quotient=8'hFF, remainder=8'h34, out_valid 1 cycle after acceptance.
- Hold out_ready=0 for 5 cycles in DONE -> out_valid, quotient and remainder stable, in_ready=0. With out_ready=1, the block returns to IDLE the next cycle and accepts a new operation the cycle after.
- Assert rst 4 cycles into CALC -> out_valid=0 and in_ready=1 once rst is released. A subsequent operation, 100/9, gives quotient=11, remainder=1.

Source files
------------

// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential restoring divider.
//   DW_DEF      : default divisor/quotient/remainder width
//   div_state_t : controller states
//   QUO_SAT_ALL : all-ones source for the saturated quotient (sliced to DW)
package seq_div_pkg;

  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Wide enough for any practical DW; users slice the low DW bits.
  localparam logic [31:0] QUO_SAT_ALL = 32'hFFFF_FFFF;

endpackage

// File: rtl/seq_unsi_div_16by8_div_step.sv
// One combinational restoring-division step.
//   p_i   [DW:0]   partial remainder entering the step
//   bit_i          next dividend bit shifted into the partial remainder
//   div_i [DW-1:0] divisor
//   p_o   [DW:0]   partial remainder leaving the step
//   q_o            quotient bit produced by this step
module div_step #(
  parameter int DW = 8
) (
  input  logic [DW:0]   p_i,
  input  logic          bit_i,
  input  logic [DW-1:0] div_i,
  output logic [DW:0]   p_o,
  output logic          q_o
);

  logic [DW:0] t_s;

  assign t_s = {p_i[DW-1:0], bit_i};

  // Trial subtraction; keep the difference when it does not go negative.
  // A set p_i[DW] means the true shifted value exceeds DW+1 bits and is
  // therefore certainly >= divisor; the modular difference is still exact.
  always_comb begin
    p_o = t_s;
    q_o = 1'b0;
    if (p_i[DW] || (t_s >= {1'b0, div_i})) begin
      p_o = t_s - {1'b0, div_i};
      q_o = 1'b1;
    end else begin
      p_o = t_s;
      q_o = 1'b0;
    end
  end

endmodule

// File: rtl/seq_unsi_div_16by8.sv
// Sequential radix-2 restoring unsigned divider, 2*DW / DW -> DW quotient
// and DW remainder, one quotient bit per cycle.
//   clk, rst               clock, asynchronous active-high reset
//   in_valid/in_ready      operand handshake (dividend, divisor)
//   out_valid/out_ready    result handshake (quotient, remainder, dz, ovf)
//   dz                     divisor was zero (quotient saturated)
//   ovf                    quotient would not fit in DW bits (saturated)
module seq_unsi_div_16by8
  import seq_div_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int CW = $clog2(DW + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*DW-1:0] dividend,
  input  logic [DW-1:0]   divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   quotient,
  output logic [DW-1:0]   remainder,
  output logic            dz,
  output logic            ovf
);

  localparam logic [DW-1:0] QUO_SAT  = QUO_SAT_ALL[DW-1:0];
  localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

  div_state_t    state_q, state_d;
  logic [DW:0]   p_q, p_d;
  logic [DW-1:0] lo_q, lo_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] div_q, div_d;
  logic [DW-1:0] quotient_q, quotient_d;
  logic [DW-1:0] remainder_q, remainder_d;
  logic          dz_q, dz_d;
  logic          ovf_q, ovf_d;

  logic [DW:0]   step_p_s;
  logic          step_q_s;

  div_step #(.DW(DW)) u_step (
    .p_i   (p_q),
    .bit_i (lo_q[DW-1]),
    .div_i (div_q),
    .p_o   (step_p_s),
    .q_o   (step_q_s)
  );

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign dz        = dz_q;
  assign ovf       = ovf_q;

  // Next-state and datapath update for the divider controller.
  always_comb begin
    state_d     = state_q;
    p_d         = p_q;
    lo_d        = lo_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dz_d        = dz_q;
    ovf_d       = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          div_d = divisor;
          if (divisor == {DW{1'b0}}) begin
            dz_d        = 1'b1;
            ovf_d       = 1'b0;
            quotient_d  = QUO_SAT;
            remainder_d = dividend[DW-1:0];
            state_d     = DONE;
          end else if (dividend[2*DW-1:DW] >= divisor) begin
            // High half already >= divisor: quotient cannot fit in DW bits.
            dz_d        = 1'b0;
            ovf_d       = 1'b1;
            quotient_d  = QUO_SAT;
            remainder_d = dividend[DW-1:0];
            state_d     = DONE;
          end else begin
            p_d     = {1'b0, dividend[2*DW-1:DW]};
            lo_d    = dividend[DW-1:0];
            quo_d   = {DW{1'b0}};
            cnt_d   = {CW{1'b0}};
            state_d = CALC;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        p_d   = step_p_s;
        lo_d  = {lo_q[DW-2:0], 1'b0};
        quo_d = {quo_q[DW-2:0], step_q_s};
        cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (cnt_q == CNT_LAST) begin
          quotient_d  = {quo_q[DW-2:0], step_q_s};
          remainder_d = step_p_s[DW-1:0];
          dz_d        = 1'b0;
          ovf_d       = 1'b0;
          state_d     = DONE;
        end else begin
          state_d = CALC;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      p_q         <= {(DW+1){1'b0}};
      lo_q        <= {DW{1'b0}};
      quo_q       <= {DW{1'b0}};
      cnt_q       <= {CW{1'b0}};
      div_q       <= {DW{1'b0}};
      quotient_q  <= {DW{1'b0}};
      remainder_q <= {DW{1'b0}};
      dz_q        <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      lo_q        <= lo_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dz_q        <= dz_d;
      ovf_q       <= ovf_d;
    end
  end

endmodule

// File: tb/tb_seq_unsi_div_16by8.sv
module tb_seq_unsi_div_16by8;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        dz;
  logic        ovf;

  int n_tests = 0;
  int n_fail  = 0;

  seq_unsi_div_16by8 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .dz        (dz),
    .ovf       (ovf)
  );

  // Unrolled reference chain built from the shared step cell.
  logic [15:0] ref_dvd;
  logic [7:0]  ref_dvs;
  logic [8:0]  ref_p [0:8];
  logic [7:0]  ref_q;

  assign ref_p[0] = {1'b0, ref_dvd[15:8]};
  for (genvar g = 0; g < 8; g++) begin : g_ref
    div_step #(.DW(8)) u_ref (
      .p_i   (ref_p[g]),
      .bit_i (ref_dvd[7-g]),
      .div_i (ref_dvs),
      .p_o   (ref_p[g+1]),
      .q_o   (ref_q[7-g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic accept_op(input logic [15:0] dvd, input logic [7:0] dvs);
    @(negedge clk);
    check("acc_rdy", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    dividend = dvd;
    divisor  = dvs;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_case(input string tag, input logic [15:0] dvd, input logic [7:0] dvs,
                          input logic [7:0] eq, input logic [7:0] er,
                          input logic edz, input logic eovf, input int elat);
    int lat;
    ref_dvd = dvd;
    ref_dvs = dvs;
    accept_op(dvd, dvs);
    wait_valid(lat);
    check({tag, "_lat"}, lat, elat);
    check({tag, "_q"}, {24'd0, quotient}, {24'd0, eq});
    check({tag, "_r"}, {24'd0, remainder}, {24'd0, er});
    check({tag, "_dz"}, {31'd0, dz}, {31'd0, edz});
    check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eovf});
    if (!edz && !eovf) begin
      check({tag, "_refq"}, {24'd0, ref_q}, {24'd0, eq});
      check({tag, "_refr"}, {24'd0, ref_p[8][7:0]}, {24'd0, er});
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_vld_drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_rdy_back"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_q_kept"}, {24'd0, quotient}, {24'd0, eq});
  endtask

  initial begin
    int lat;
    int bad;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = 16'd0;
    divisor   = 8'd0;
    ref_dvd   = 16'd0;
    ref_dvs   = 8'd1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_q", {24'd0, quotient}, 32'd0);
    check("rst_r", {24'd0, remainder}, 32'd0);
    check("rst_dz", {31'd0, dz}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);

    // Directed vectors: tag, dividend, divisor, quotient, remainder, dz, ovf, latency
    run_case("d200_7",   16'd200,   8'd7,    8'd28,   8'd4,    1'b0, 1'b0, 9);
    run_case("fe01_ff",  16'hFE01,  8'hFF,   8'hFF,   8'h00,   1'b0, 1'b0, 9);
    run_case("dz1234",   16'd1234,  8'd0,    8'hFF,   8'hD2,   1'b1, 1'b0, 1);
    run_case("ovf1234",  16'h1234,  8'h12,   8'hFF,   8'h34,   1'b0, 1'b1, 1);
    run_case("h1234_13", 16'h1234,  8'h13,   8'hF5,   8'h05,   1'b0, 1'b0, 9);
    run_case("h00ff_1",  16'h00FF,  8'h01,   8'hFF,   8'h00,   1'b0, 1'b0, 9);
    run_case("dz_after", 16'h0000,  8'h00,   8'hFF,   8'h00,   1'b1, 1'b0, 1);

    // Back-pressure: 1000/33 = 30 r 10, with stray in_valid while busy.
    accept_op(16'd1000, 8'd33);
    @(negedge clk);
    in_valid = 1'b1;
    dividend = 16'hFFFF;
    divisor  = 8'h01;
    wait_valid(lat);
    check("hold_lat", lat, 32'd9);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_vld", {31'd0, out_valid}, 32'd1);
      check("hold_rdy", {31'd0, in_ready}, 32'd0);
      check("hold_q", {24'd0, quotient}, 32'd30);
      check("hold_r", {24'd0, remainder}, 32'd10);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("hold_vld_drop", {31'd0, out_valid}, 32'd0);
    check("hold_rdy_back", {31'd0, in_ready}, 32'd1);
    run_case("after_hold", 16'd200, 8'd7, 8'd28, 8'd4, 1'b0, 1'b0, 9);

    // Reset 4 cycles into CALC aborts the operation.
    accept_op(16'd200, 8'd7);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_vld", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_vld", {31'd0, out_valid}, 32'd0);
    check("post_rst_rdy", {31'd0, in_ready}, 32'd1);
    check("post_rst_q", {24'd0, quotient}, 32'd0);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    check("post_rst_quiet", bad, 32'd0);
    run_case("d100_9", 16'd100, 8'd9, 8'd11, 8'd1, 1'b0, 1'b0, 9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
